// File: rtl/pc_pkg.sv
// Shared program-counter types and default constants for the PC datapath.
package pc_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] pc_t;

   localparam pc_t DEFAULT_RESET_PC = 32'h0000_0000;
   localparam int  DEFAULT_PC_STEP  = 4;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential step or PC-relative branch target.
// Optional branch-target alignment gate under PC_ADDER_MISALIGN_CHK_EN.
module pc_next_calc
   import pc_pkg::*;
#(
   parameter int PC_STEP = DEFAULT_PC_STEP
) (
   input  pc_t         pc,
   input  logic        ALU_zero,
   input  logic        branch,
   input  logic [63:0] branch_offset,
   output pc_t         pc_next,
   output logic        branch_taken
`ifdef PC_ADDER_MISALIGN_CHK_EN
   ,
   output logic        misalign
`endif
);

   pc_t  seq_pc;
   pc_t  target_pc;
   logic take_raw;

   // Only the low XLEN bits of the offset matter; the upper half is dropped.
   logic unused_offset_hi;
   assign unused_offset_hi = ^branch_offset[63:XLEN];

   assign seq_pc    = pc + pc_t'(PC_STEP);
   assign target_pc = pc + branch_offset[XLEN-1:0];
   assign take_raw  = branch && ALU_zero;

`ifdef PC_ADDER_MISALIGN_CHK_EN
   // A misaligned target suppresses the branch and falls through sequentially.
   assign misalign     = take_raw && (target_pc[1:0] != 2'b00);
   assign branch_taken = take_raw && !misalign;
`else
   assign branch_taken = take_raw;
`endif

   assign pc_next = branch_taken ? target_pc : seq_pc;

endmodule

// File: rtl/pc_adder.sv
// Program counter register with sequential increment and conditional branch.
// Define PC_ADDER_MISALIGN_CHK_EN to add the registered misalign_o flag.
module pc_adder
   import pc_pkg::*;
#(
   parameter pc_t RESET_PC = DEFAULT_RESET_PC,
   parameter int  PC_STEP  = DEFAULT_PC_STEP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ALU_zero,
   input  logic        branch,
   input  logic [63:0] branch_offset,
   output pc_t         pc_out,
   output pc_t         pc_next,
   output logic        branch_taken
`ifdef PC_ADDER_MISALIGN_CHK_EN
   ,
   output logic        misalign_o
`endif
);

`ifdef PC_ADDER_MISALIGN_CHK_EN
   logic misalign;
`endif

   pc_next_calc #(
      .PC_STEP (PC_STEP)
   ) u_next_calc (
      .pc            (pc_out),
      .ALU_zero      (ALU_zero),
      .branch        (branch),
      .branch_offset (branch_offset),
      .pc_next       (pc_next),
      .branch_taken  (branch_taken)
`ifdef PC_ADDER_MISALIGN_CHK_EN
      ,
      .misalign      (misalign)
`endif
   );

   // Synchronous active-low reset overrides any pending branch.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_out <= RESET_PC;
      end else begin
         pc_out <= pc_next;
      end
   end

`ifdef PC_ADDER_MISALIGN_CHK_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         misalign_o <= 1'b0;
      end else begin
         misalign_o <= misalign;
      end
   end
`endif

endmodule

// File: tb/tb_pc_adder.sv
// Self-checking bench for pc_adder: directed vectors plus randomized traffic
// against an arithmetic reference model of the program counter.
module tb_pc_adder;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          PC_STEP  = 4;

   logic        clk;
   logic        rst;
   logic        ALU_zero;
   logic        branch;
   logic [63:0] branch_offset;
   logic [31:0] pc_out;
   logic [31:0] pc_next;
   logic        branch_taken;
`ifdef PC_ADDER_MISALIGN_CHK_EN
   logic        misalign_o;
   logic        exp_mis;
`endif

   int          errors;
   int          checks;
   logic [31:0] exp_pc;

   pc_adder #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ALU_zero      (ALU_zero),
      .branch        (branch),
      .branch_offset (branch_offset),
      .pc_out        (pc_out),
      .pc_next       (pc_next),
      .branch_taken  (branch_taken)
`ifdef PC_ADDER_MISALIGN_CHK_EN
      ,
      .misalign_o    (misalign_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Reference: a branch is taken when both flags are set (and, with the
   // alignment check, the target is word aligned); otherwise step forward.
   task automatic applyStimulus(input logic r, input logic b, input logic z,
                                input logic [63:0] off);
      logic [31:0] target;
      logic [31:0] model_next;
      logic        take;
      rst           = r;
      branch        = b;
      ALU_zero      = z;
      branch_offset = off;
      target = exp_pc + off[31:0];
      take   = b && z;
`ifdef PC_ADDER_MISALIGN_CHK_EN
      exp_mis = take && (target % 4 != 0);
      if (exp_mis) take = 1'b0;
`endif
      model_next = take ? target : exp_pc + PC_STEP;
      #1;
      checkOutput("branch_taken", {31'd0, branch_taken}, {31'd0, take});
      checkOutput("pc_next", pc_next, model_next);
      @(posedge clk);
      #1;
      exp_pc = r ? model_next : RESET_PC;
      checkOutput("pc_out", pc_out, exp_pc);
`ifdef PC_ADDER_MISALIGN_CHK_EN
      checkOutput("misalign_o", {31'd0, misalign_o}, {31'd0, exp_mis && r});
`endif
   endtask

   initial begin
      logic [63:0] off;
      logic        r;
      errors        = 0;
      checks        = 0;
      exp_pc        = RESET_PC;
      rst           = 1'b0;
      branch        = 1'b0;
      ALU_zero      = 1'b0;
      branch_offset = 64'd0;
      @(posedge clk);
      #1;

      applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 64'd100);
      checkOutput("reset_state", pc_out, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
      checkOutput("seq_4", pc_out, 32'd4);
      applyStimulus(1'b1, 1'b0, 1'b1, 64'd0);
      checkOutput("seq_8", pc_out, 32'd8);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'd40);
      checkOutput("seq_12", pc_out, 32'd12);
      applyStimulus(1'b1, 1'b1, 1'b1, 64'd8);
      checkOutput("branch_fwd", pc_out, 32'd20);
      applyStimulus(1'b1, 1'b1, 1'b0, 64'd16);
      checkOutput("branch_not_taken", pc_out, 32'd24);
      applyStimulus(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
      checkOutput("branch_back", pc_out, 32'd8);
      applyStimulus(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4);
      checkOutput("to_top", pc_out, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
      checkOutput("wrap", pc_out, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 64'd64);
      checkOutput("reset_over_branch", pc_out, RESET_PC);
      applyStimulus(1'b1, 1'b1, 1'b1, 64'h1_0000_0004);
      checkOutput("offset_hi_ignored", pc_out, 32'd4);
      applyStimulus(1'b1, 1'b1, 1'b1, 64'd0);
      checkOutput("offset_zero_hold", pc_out, 32'd4);
      applyStimulus(1'b1, 1'b1, 1'b1, 64'd4);
      checkOutput("to_8", pc_out, 32'd8);
`ifdef PC_ADDER_MISALIGN_CHK_EN
      applyStimulus(1'b1, 1'b1, 1'b1, 64'd2);
      checkOutput("misalign_pc", pc_out, 32'd12);
      checkOutput("misalign_flag", {31'd0, misalign_o}, 32'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'd0);
      checkOutput("misalign_clear", {31'd0, misalign_o}, 32'd0);
`endif

      for (int i = 0; i < 200; i++) begin
         r = ($urandom_range(15) != 0);
         case ($urandom_range(2))
            0:       off = {{32{1'b0}}, 32'($urandom_range(255))} << 2;
            1:       off = -({{32{1'b0}}, 32'($urandom_range(255))} << 2);
            default: off = {$urandom, $urandom};
         endcase
         applyStimulus(r, 1'($urandom_range(1)), 1'($urandom_range(1)), off);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
